// File: rtl/clock_time_core_pkg.sv
// ----------------------------------------------------------------------------
// clock_time_core_pkg
// Shared definitions for the HH:MM:SS timekeeper: FSM state encodings,
// edit_sel codes, digit limits and the state -> edit_sel decode.
// Optional feature macro used by the design: CLOCK_TIME_ALARM_EN.
// ----------------------------------------------------------------------------
package clock_time_core_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_ALM_HR  = 3'd3,
        ST_ALM_MIN = 3'd4
    } state_t;

    localparam logic [1:0] SEL_RUN = 2'b00;
    localparam logic [1:0] SEL_HR  = 2'b01;
    localparam logic [1:0] SEL_MIN = 2'b10;
    localparam logic [1:0] SEL_ALM = 2'b11;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    function automatic logic [1:0] edit_sel_of(input state_t s);
        case (s)
            ST_SET_HR:  return SEL_HR;
            ST_SET_MIN: return SEL_MIN;
            ST_ALM_HR:  return SEL_ALM;
            ST_ALM_MIN: return SEL_ALM;
            default:    return SEL_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_time_core_if.sv
// ----------------------------------------------------------------------------
// clock_time_core_if
// Groups the timekeeper's control inputs and display/status outputs.
//   en, mode_btn, inc_btn : count enable and single-cycle button pulses
//   ch0..ch5              : BCD digits (ch0 sec units ... ch5 hr tens)
//   edit_sel              : 00 RUN, 01 hours, 10 minutes, 11 alarm edit
//   sec_pulse             : one-cycle pulse when the seconds digits update
//   alarm                 : alarm active
//   dbg_state             : raw FSM state for checkers
// master = the controlling side (board / bench), slave = the core.
// Button pulses are single-cycle strobes; there is no ready/acknowledge:
// a pulse is consumed on the clock edge where it is high.
// ----------------------------------------------------------------------------
interface clock_time_core_if;
    logic       en;
    logic       mode_btn;
    logic       inc_btn;
    logic [3:0] ch0;
    logic [3:0] ch1;
    logic [3:0] ch2;
    logic [3:0] ch3;
    logic [3:0] ch4;
    logic [3:0] ch5;
    logic [1:0] edit_sel;
    logic       sec_pulse;
    logic       alarm;
    logic [2:0] dbg_state;

    modport master (
        output en, mode_btn, inc_btn,
        input  ch0, ch1, ch2, ch3, ch4, ch5, edit_sel, sec_pulse, alarm, dbg_state
    );

    modport slave (
        input  en, mode_btn, inc_btn,
        output ch0, ch1, ch2, ch3, ch4, ch5, edit_sel, sec_pulse, alarm, dbg_state
    );
endinterface

// File: rtl/clock_time_core_bcd_wrap_cnt.sv
// ----------------------------------------------------------------------------
// clock_time_core_bcd_wrap_cnt
// Two-digit BCD counter that wraps from MAX back to 00.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear to 00 (wins over inc)
//   inc         : advance by one
//   tens, units : registered count
//   nxt_tens/units : value the register takes on the coming edge
//   carry       : inc while at MAX (the wrap cycle)
// ----------------------------------------------------------------------------
module clock_time_core_bcd_wrap_cnt #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [3:0] nxt_tens,
    output logic [3:0] nxt_units,
    output logic       carry
);
    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MAX % 10);

    logic at_max;
    assign at_max = (tens == MAX_T) && (units == MAX_U);
    assign carry  = inc && !clr && at_max;

    always_comb begin
        nxt_tens  = tens;
        nxt_units = units;
        if (clr) begin
            nxt_tens  = 4'd0;
            nxt_units = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                nxt_tens  = 4'd0;
                nxt_units = 4'd0;
            end else if (units == 4'd9) begin
                nxt_tens  = tens + 4'd1;
                nxt_units = 4'd0;
            end else begin
                nxt_units = units + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else begin
            tens  <= nxt_tens;
            units <= nxt_units;
        end
    end
endmodule

// File: rtl/clock_time_core.sv
// ----------------------------------------------------------------------------
// clock_time_core
// 24-hour HH:MM:SS timekeeper with hour/minute setting.
//   clk  : system clock, rising edge
//   cr   : asynchronous active-low clear
//   bus  : clock_time_core_if.slave (en, buttons in; digits, edit_sel,
//          sec_pulse, alarm, dbg_state out)
// Parameters: TICK_DIV (clk cycles per second, >=2), ALARM_SECS.
// Optional feature: define CLOCK_TIME_ALARM_EN to add the alarm time,
// its edit states and the timed alarm output; otherwise alarm is 0.
// ----------------------------------------------------------------------------
module clock_time_core
    import clock_time_core_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int ALARM_SECS = 60
) (
    input  logic             clk,
    input  logic             cr,
    clock_time_core_if.slave bus
);
    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic          in_run, edit_inc, tick, leave_set_min;
    logic          sec_carry, min_carry, hr_carry;
    logic [3:0]    sec_t, sec_u, min_t, min_u, hr_t, hr_u;
    logic [3:0]    sec_nt, sec_nu, min_nt, min_nu, hr_nt, hr_nu;
    logic [1:0]    edit_sel_q;
    logic          sec_pulse_q;
    logic [23:0]   disp;

    // mode_btn always wins: a simultaneous inc is dropped, and a mode press
    // on a tick cycle in RUN discards that tick.
    assign in_run        = (state_q == ST_RUN);
    assign edit_inc      = bus.inc_btn && !bus.mode_btn;
    assign tick          = in_run && bus.en && !bus.mode_btn && (presc_q == PRESC_LAST);
    assign leave_set_min = (state_q == ST_SET_MIN) && bus.mode_btn;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (bus.mode_btn) state_d = ST_SET_HR;
            ST_SET_HR:  if (bus.mode_btn) state_d = ST_SET_MIN;
`ifdef CLOCK_TIME_ALARM_EN
            ST_SET_MIN: if (bus.mode_btn) state_d = ST_ALM_HR;
            ST_ALM_HR:  if (bus.mode_btn) state_d = ST_ALM_MIN;
            ST_ALM_MIN: if (bus.mode_btn) state_d = ST_RUN;
`else
            ST_SET_MIN: if (bus.mode_btn) state_d = ST_RUN;
`endif
            default:    state_d = ST_RUN;
        endcase
    end

    // ---------------- prescaler ----------------
    // Advances only in RUN with en=1; held through a mode press so the
    // edit states see it frozen; restarted when seconds are cleared.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            presc_q <= '0;
        end else if (leave_set_min) begin
            presc_q <= '0;
        end else if (in_run && bus.en && !bus.mode_btn) begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // ---------------- time counters ----------------
    clock_time_core_bcd_wrap_cnt #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst_n(cr), .clr(leave_set_min), .inc(tick),
        .tens(sec_t), .units(sec_u), .nxt_tens(sec_nt), .nxt_units(sec_nu),
        .carry(sec_carry)
    );

    // Minute edits never ripple into the hour: min_carry only counts in RUN.
    clock_time_core_bcd_wrap_cnt #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .rst_n(cr), .clr(1'b0),
        .inc(sec_carry || ((state_q == ST_SET_MIN) && edit_inc)),
        .tens(min_t), .units(min_u), .nxt_tens(min_nt), .nxt_units(min_nu),
        .carry(min_carry)
    );

    clock_time_core_bcd_wrap_cnt #(.MAX(HR_MAX)) u_hr (
        .clk(clk), .rst_n(cr), .clr(1'b0),
        .inc((in_run && min_carry) || ((state_q == ST_SET_HR) && edit_inc)),
        .tens(hr_t), .units(hr_u), .nxt_tens(hr_nt), .nxt_units(hr_nu),
        .carry(hr_carry)
    );

    // ---------------- status registers ----------------
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            edit_sel_q  <= SEL_RUN;
            sec_pulse_q <= 1'b0;
        end else begin
            edit_sel_q  <= edit_sel_of(state_d);
            sec_pulse_q <= tick;
        end
    end

`ifdef CLOCK_TIME_ALARM_EN
    localparam int AW = $clog2(ALARM_SECS + 1);

    logic [3:0]    ah_t, ah_u, am_t, am_u, ah_nt, ah_nu, am_nt, am_nu;
    logic          ah_carry, am_carry, alm_hit, show_alm;
    logic          alarm_q;
    logic [AW-1:0] alm_cnt_q;
    logic [23:0]   disp_d, disp_q;

    clock_time_core_bcd_wrap_cnt #(.MAX(HR_MAX)) u_alm_hr (
        .clk(clk), .rst_n(cr), .clr(1'b0),
        .inc((state_q == ST_ALM_HR) && edit_inc),
        .tens(ah_t), .units(ah_u), .nxt_tens(ah_nt), .nxt_units(ah_nu),
        .carry(ah_carry)
    );

    clock_time_core_bcd_wrap_cnt #(.MAX(MIN_MAX)) u_alm_min (
        .clk(clk), .rst_n(cr), .clr(1'b0),
        .inc((state_q == ST_ALM_MIN) && edit_inc),
        .tens(am_t), .units(am_u), .nxt_tens(am_nt), .nxt_units(am_nu),
        .carry(am_carry)
    );

    // The tick that rolls seconds to 00 and lands on the alarm hh:mm.
    assign alm_hit  = tick && sec_carry &&
                      ({hr_nt, hr_nu, min_nt, min_nu} == {ah_t, ah_u, am_t, am_u});
    assign show_alm = (state_d == ST_ALM_HR) || (state_d == ST_ALM_MIN);

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            alarm_q   <= 1'b0;
            alm_cnt_q <= '0;
        end else if (alm_hit) begin
            alarm_q   <= 1'b1;
            alm_cnt_q <= '0;
        end else if (alarm_q) begin
            if (bus.mode_btn || bus.inc_btn) begin
                alarm_q <= 1'b0;
            end else if (tick) begin
                if (alm_cnt_q == AW'(ALARM_SECS - 1)) alarm_q <= 1'b0;
                else                                  alm_cnt_q <= alm_cnt_q + AW'(1);
            end
        end
    end

    // Display is registered from next-cycle values so it stays aligned with
    // the counters while switching between time and alarm views.
    always_comb begin
        disp_d = {hr_nt, hr_nu, min_nt, min_nu, sec_nt, sec_nu};
        if (show_alm) disp_d = {ah_nt, ah_nu, am_nt, am_nu, 8'h00};
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) disp_q <= '0;
        else     disp_q <= disp_d;
    end

    assign disp      = disp_q;
    assign bus.alarm = alarm_q;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, hr_carry, ah_carry, am_carry,
                           sec_t, sec_u, min_t, min_u, hr_t, hr_u};
`else
    localparam int unused_alarm_secs = ALARM_SECS;

    assign disp      = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
    assign bus.alarm = 1'b0;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, hr_carry, sec_nt, sec_nu, min_nt, min_nu, hr_nt, hr_nu};
`endif

    assign bus.ch0       = disp[3:0];
    assign bus.ch1       = disp[7:4];
    assign bus.ch2       = disp[11:8];
    assign bus.ch3       = disp[15:12];
    assign bus.ch4       = disp[19:16];
    assign bus.ch5       = disp[23:20];
    assign bus.edit_sel  = edit_sel_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_clock_time_core.sv
// ----------------------------------------------------------------------------
// tb_clock_time_core
// Directed bench for clock_time_core with TICK_DIV=4, ALARM_SECS=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, after the registers have settled.
// ----------------------------------------------------------------------------
module tb_clock_time_core;
    localparam int TICK_DIV   = 4;
    localparam int ALARM_SECS = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic cr;
    always #5 clk = ~clk;

    clock_time_core_if bus();

    clock_time_core #(.TICK_DIV(TICK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
        .clk(clk),
        .cr (cr),
        .bus(bus)
    );

    int checks      = 0;
    int failures    = 0;
    int pulse_cnt   = 0;
    int illegal_cnt = 0;
    int pulses_before;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] disp();
        return {bus.ch5, bus.ch4, bus.ch3, bus.ch2, bus.ch1, bus.ch0};
    endfunction

    function automatic bit bcd_ok(input logic [23:0] d);
        bit ok;
        ok = (d[3:0] <= 4'd9) && (d[7:4] <= 4'd5) &&
             (d[11:8] <= 4'd9) && (d[15:12] <= 4'd5) &&
             (d[19:16] <= 4'd9) && (d[23:20] <= 4'd2);
        if (d[23:20] == 4'd2 && d[19:16] > 4'd3) ok = 1'b0;
        return ok;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.sec_pulse === 1'b1) pulse_cnt++;
        if (!bcd_ok(disp())) illegal_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_mode();
        bus.mode_btn = 1'b1;
        step();
        bus.mode_btn = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.inc_btn = 1'b1;
            step();
            bus.inc_btn = 1'b0;
        end
    endtask

    // One mode press out of SET_MIN, plus the alarm edit states if present.
    task automatic leave_set_min();
        pulse_mode();
`ifdef CLOCK_TIME_ALARM_EN
        pulse_mode();
        pulse_mode();
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cr           = 1'b0;
        bus.en       = 1'b0;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        steps(2);
        check("rst_time",      32'(disp()), 32'h000000);
        check("rst_edit_sel",  32'(bus.edit_sel), 32'd0);
        check("rst_sec_pulse", 32'(bus.sec_pulse), 32'd0);
        check("rst_alarm",     32'(bus.alarm), 32'd0);
        check("rst_state",     32'(bus.dbg_state), 32'd0);

        // 1. free run: 40 cycles = 10 ticks
        cr        = 1'b1;
        bus.en    = 1'b1;
        pulse_cnt = 0;
        steps(3);
        check("first_tick_not_yet", 32'(disp()), 32'h000000);
        step();
        check("first_tick", 32'(disp()), 32'h000001);
        check("first_tick_pulse", 32'(bus.sec_pulse), 32'd1);
        steps(36);
        check("run40_time", 32'(disp()), 32'h000010);
        check("run40_pulses", 32'(pulse_cnt), 32'd10);

        // 2. set 23:59 and roll over midnight
        pulse_mode();
        check("sethr_sel", 32'(bus.edit_sel), 32'd1);
        pulse_inc(23);
        check("sethr_23", 32'(disp()), 32'h230010);
        pulse_mode();
        check("setmin_sel", 32'(bus.edit_sel), 32'd2);
        pulse_inc(59);
        check("setmin_59", 32'(disp()), 32'h235910);
        leave_set_min();
        check("leave_clears_sec", 32'(disp()), 32'h235900);
        check("back_to_run", 32'(bus.edit_sel), 32'd0);
        steps(236);
        check("pre_midnight", 32'(disp()), 32'h235959);
        steps(4);
        check("midnight", 32'(disp()), 32'h000000);
        check("bcd_legal", 32'(illegal_cnt), 32'd0);

        // 3. hour and minute wrap while editing
        pulse_mode();
        check("t3_sel_hr", 32'(bus.edit_sel), 32'd1);
        pulse_inc(25);
        check("hr_wrap", 32'(disp()), 32'h010000);
        pulse_mode();
        pulse_inc(61);
        check("min_wrap_no_carry", 32'(disp()), 32'h010100);
        leave_set_min();

        // 4. en=0 freezes time and prescaler
        pulses_before = pulse_cnt;
        bus.en = 1'b0;
        steps(100);
        check("en0_time", 32'(disp()), 32'h010100);
        check("en0_pulses", 32'(pulse_cnt), 32'(pulses_before));
        bus.en = 1'b1;
        steps(3);
        check("resume_3cyc", 32'(disp()), 32'h010100);
        step();
        check("resume_tick", 32'(disp()), 32'h010101);
        check("resume_pulse", 32'(bus.sec_pulse), 32'd1);
        steps(2);
        bus.en = 1'b0;
        steps(50);
        bus.en = 1'b1;
        step();
        check("midcount_hold", 32'(disp()), 32'h010101);
        step();
        check("midcount_tick", 32'(disp()), 32'h010102);

        // 5. mode on a tick cycle, mode+inc together
        pulse_mode();
        pulse_inc(23);
        pulse_mode();
        pulse_inc(59);
        leave_set_min();
        check("t5_zero", 32'(disp()), 32'h000000);
        steps(20);
        check("t5_at_05", 32'(disp()), 32'h000005);
        steps(3);
        pulses_before = pulse_cnt;
        pulse_mode();
        check("tick_mode_sel", 32'(bus.edit_sel), 32'd1);
        check("tick_mode_time", 32'(disp()), 32'h000005);
        check("tick_mode_nopulse", 32'(pulse_cnt), 32'(pulses_before));
        bus.mode_btn = 1'b1;
        bus.inc_btn  = 1'b1;
        step();
        check("modeinc_hr_sel", 32'(bus.edit_sel), 32'd2);
        check("modeinc_hr_time", 32'(disp()), 32'h000005);
        step();
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
`ifdef CLOCK_TIME_ALARM_EN
        pulse_mode();
        pulse_mode();
`endif
        check("modeinc_min_sel", 32'(bus.edit_sel), 32'd0);
        check("modeinc_min_time", 32'(disp()), 32'h000000);

`ifdef CLOCK_TIME_ALARM_EN
        // 6. alarm at 00:01
        pulse_mode();
        pulse_mode();
        pulse_mode();
        check("alm_sel", 32'(bus.edit_sel), 32'd3);
        pulse_mode();
        pulse_inc(1);
        check("alm_view", 32'(disp()), 32'h000100);
        pulse_mode();
        check("alm_back_run", 32'(disp()), 32'h000000);
        steps(232);
        check("alm_at_58", 32'(disp()), 32'h000058);
        check("alm_off_58", 32'(bus.alarm), 32'd0);
        steps(8);
        check("alm_on_time", 32'(disp()), 32'h000100);
        check("alm_on", 32'(bus.alarm), 32'd1);
        steps(8);
        check("alm_still_on", 32'(bus.alarm), 32'd1);
        steps(4);
        check("alm_timeout_time", 32'(disp()), 32'h000103);
        check("alm_timeout", 32'(bus.alarm), 32'd0);
        pulse_mode();
        pulse_mode();
        pulse_inc(59);
        leave_set_min();
        steps(240);
        check("alm2_on", 32'(bus.alarm), 32'd1);
        steps(4);
        pulse_inc(1);
        check("alm2_ack", 32'(bus.alarm), 32'd0);
        check("alm2_time", 32'(disp()), 32'h000101);
`else
        check("alarm_tied_low", 32'(bus.alarm), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
